// File: rtl/sr_wb_loader.sv
// rtl/sr_wb_loader.sv - loads a scan chain into the SR programming port, optional readback
module sr_wb_loader #(
    parameter int          WIDTH     = 164,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          TIMEOUT   = 255
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic        rb_en_i,
    input  logic [31:0] in_data_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    output logic [31:0] out_data_o,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] wb_addr_o,
    output logic        valid_o,
    output logic        wen_o,
    output logic [31:0] wProgData_o,
    input  logic [31:0] rProgData_i,
    input  logic        ready_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o
);
    localparam int NWORDS = (WIDTH + 31) / 32;
    localparam int IDXW   = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int TW     = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(NWORDS - 1);
    localparam logic [TW-1:0]   TO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [31:0]     LAST_MASK = (WIDTH % 32 == 0) ? 32'hFFFF_FFFF
                                            : ((32'd1 << (WIDTH % 32)) - 32'd1);

    typedef enum logic [2:0] {IDLE, FETCH, WRITE, READ, EMIT, DONE} state_t;

    state_t          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic            rb_en_q, rb_en_d;
    logic            error_q, error_d;
    logic            valid_q, valid_d;
    logic            wen_q, wen_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            hit, expire, bus_d, bus_q;

    function automatic logic [31:0] word_mask(input logic [IDXW-1:0] i);
        return (i == LAST_IDX) ? LAST_MASK : 32'hFFFF_FFFF;
    endfunction

    // A timeout is declared on the cycle the count would reach TIMEOUT; ready in that cycle wins.
    assign hit    = valid_q & ready_i;
    assign expire = valid_q & ~ready_i & (tcnt_q == TO_LAST);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rb_en_d = rb_en_q;
        error_d = error_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: if (start_i) begin
                rb_en_d = rb_en_i;
                idx_d   = '0;
                error_d = 1'b0;
                state_d = FETCH;
            end
            FETCH: if (in_valid_i) begin
                wdata_d = in_data_i & word_mask(idx_q);
                state_d = WRITE;
            end
            WRITE: if (hit) begin
                if (idx_q != LAST_IDX) begin
                    idx_d   = idx_q + 1'b1;
                    state_d = FETCH;
                end else if (rb_en_q) begin
                    idx_d   = '0;
                    state_d = READ;
                end else begin
                    state_d = DONE;
                end
            end else if (expire) begin
                error_d = 1'b1;
                state_d = DONE;
            end
            READ: if (hit) begin
                rdata_d = rProgData_i & word_mask(idx_q);
                state_d = EMIT;
            end else if (expire) begin
                error_d = 1'b1;
                state_d = DONE;
            end
            EMIT: if (out_ready_i) begin
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = READ;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Going straight from WRITE to READ leaves valid low for one cycle between transactions.
        bus_d   = (state_d == WRITE) || (state_d == READ);
        bus_q   = (state_q == WRITE) || (state_q == READ);
        valid_d = bus_d && (!bus_q || (state_d == state_q));
        wen_d   = (state_d == WRITE);
        addr_d  = bus_d ? (BASE_ADDR + {{(30 - IDXW){1'b0}}, idx_d, 2'b00}) : addr_q;
        tcnt_d  = (valid_q && !ready_i) ? tcnt_q + 1'b1 : '0;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            tcnt_q  <= '0;
            rb_en_q <= 1'b0;
            error_q <= 1'b0;
            valid_q <= 1'b0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tcnt_q  <= tcnt_d;
            rb_en_q <= rb_en_d;
            error_q <= error_d;
            valid_q <= valid_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign in_ready_o  = (state_q == FETCH);
    assign out_valid_o = (state_q == EMIT);
    assign out_data_o  = rdata_q;
    assign wb_addr_o   = addr_q;
    assign valid_o     = valid_q;
    assign wen_o       = wen_q;
    assign wProgData_o = wdata_q;
    assign busy_o      = (state_q != IDLE) && (state_q != DONE);
    assign done_o      = (state_q == DONE);
    assign error_o     = error_q;
endmodule
